// File: rtl/ssd_disp_arb.sv
// Four-digit seven-segment scan driver shared by two sources.
// Ownership rotates between A and B on frame boundaries only.
module ssd_disp_arb #(
  parameter int REFRESH_DIV = 50000,
  parameter int HOLD_FRAMES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic [15:0] data_a,
  input  logic        req_b,
  input  logic [15:0] data_b,
  input  logic        blank_lz,
  output logic        grant_a,
  output logic        grant_b,
  output logic [1:0]  ssd_en_ctl,
  output logic [3:0]  ssd_ctl,
  output logic [3:0]  ssd_in,
  output logic        frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [HW-1:0] hold_q, hold_d;
  state_t        state_q, state_d;
  logic          grant_a_q, grant_a_d;
  logic          grant_b_q, grant_b_d;

  logic          tick;
  logic          fd_int;
  logic [15:0]   sel;
  logic [3:0]    dig;
  logic [3:0]    hot;
  logic          lz;
  logic          blank;

  // Prescaler and digit slot index.
  always_comb begin
    tick   = (cnt_q == CNT_MAX);
    fd_int = tick && (idx_q == 2'd3);
    cnt_d  = tick ? '0 : cnt_q + 1'b1;
    idx_d  = tick ? idx_q + 2'd1 : idx_q;
  end

  // Arbiter next state; decisions only at the frame boundary.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (fd_int) begin
      unique case (state_q)
        IDLE: begin
          if (req_a) begin
            state_d = OWN_A;
            hold_d  = '0;
          end else if (req_b) begin
            state_d = OWN_B;
            hold_d  = '0;
          end
        end
        OWN_A: begin
          if (req_a && hold_q < HOLD_MAX) begin
            hold_d = hold_q + 1'b1;
          end else if (req_b) begin
            state_d = OWN_B;
            hold_d  = '0;
          end else if (req_a) begin
            hold_d = '0;
          end else begin
            state_d = IDLE;
            hold_d  = '0;
          end
        end
        OWN_B: begin
          if (req_b && hold_q < HOLD_MAX) begin
            hold_d = hold_q + 1'b1;
          end else if (req_a) begin
            state_d = OWN_A;
            hold_d  = '0;
          end else if (req_b) begin
            hold_d = '0;
          end else begin
            state_d = IDLE;
            hold_d  = '0;
          end
        end
        default: begin
          state_d = IDLE;
          hold_d  = '0;
        end
      endcase
    end
    grant_a_d = (state_d == OWN_A);
    grant_b_d = (state_d == OWN_B);
  end

  // State registers; reset wins over any frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      hold_q    <= '0;
      state_q   <= IDLE;
      grant_a_q <= 1'b0;
      grant_b_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      state_q   <= state_d;
      grant_a_q <= grant_a_d;
      grant_b_q <= grant_b_d;
    end
  end

  // Source select and per-slot digit decode with leading-zero blanking.
  always_comb begin
    sel = 16'h0000;
    dig = 4'h0;
    hot = 4'b1111;
    lz  = 1'b0;
    unique case (state_q)
      OWN_A:   sel = data_a;
      OWN_B:   sel = data_b;
      default: sel = 16'h0000;
    endcase
    unique case (idx_q)
      2'd0: begin
        dig = sel[3:0];
        hot = 4'b1110;
        lz  = 1'b0;
      end
      2'd1: begin
        dig = sel[7:4];
        hot = 4'b1101;
        lz  = (sel[15:4] == 12'h000);
      end
      2'd2: begin
        dig = sel[11:8];
        hot = 4'b1011;
        lz  = (sel[15:8] == 8'h00);
      end
      default: begin
        dig = sel[15:12];
        hot = 4'b0111;
        lz  = (sel[15:12] == 4'h0);
      end
    endcase
    blank = rst || (state_q == IDLE) || (blank_lz && lz);
  end

  assign ssd_ctl    = blank ? 4'b1111 : hot;
  assign ssd_in     = blank ? 4'h0 : dig;
  assign ssd_en_ctl = idx_q;
  assign frame_done = fd_int && !rst;
  assign grant_a    = grant_a_q;
  assign grant_b    = grant_b_q;

endmodule

// File: tb/tb_ssd_disp_arb.sv
// Scoreboard bench for ssd_disp_arb.
// Reference model tracks time as a cycle count and owner as an integer.
module tb_ssd_disp_arb;

  localparam int RD    = 4;
  localparam int HF    = 2;
  localparam int FRAME = 4 * RD;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a, req_b, blank_lz;
  logic [15:0] data_a, data_b;
  logic        grant_a, grant_b, frame_done;
  logic [1:0]  ssd_en_ctl;
  logic [3:0]  ssd_ctl, ssd_in;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    int         cyc;
    logic       ga;
    logic       gb;
    logic [1:0] en;
    logic [3:0] ctl;
    logic [3:0] din;
    logic       fd;
  } exp_t;

  exp_t sb[$];

  // model state: cycles since reset release, owner 0=none 1=A 2=B
  int m_cyc   = 0;
  int m_own   = 0;
  int m_hold  = 0;
  bit m_valid = 0;

  ssd_disp_arb #(
    .REFRESH_DIV(RD),
    .HOLD_FRAMES(HF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_a      (req_a),
    .data_a     (data_a),
    .req_b      (req_b),
    .data_b     (data_b),
    .blank_lz   (blank_lz),
    .grant_a    (grant_a),
    .grant_b    (grant_b),
    .ssd_en_ctl (ssd_en_ctl),
    .ssd_ctl    (ssd_ctl),
    .ssd_in     (ssd_in),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // model: ownership changes only at the last cycle of a frame
  always @(posedge clk) begin
    if (rst) begin
      m_cyc   = 0;
      m_own   = 0;
      m_hold  = 0;
      m_valid = 1;
    end else if (m_valid) begin
      if (m_cyc % FRAME == FRAME - 1) begin
        bit mine, other;
        mine  = (m_own == 1) ? req_a : req_b;
        other = (m_own == 1) ? req_b : req_a;
        if (m_own == 0) begin
          m_own  = req_a ? 1 : (req_b ? 2 : 0);
          m_hold = 0;
        end else if (mine && m_hold < HF - 1) begin
          m_hold++;
        end else if (other) begin
          m_own  = 3 - m_own;
          m_hold = 0;
        end else if (mine) begin
          m_hold = 0;
        end else begin
          m_own  = 0;
          m_hold = 0;
        end
      end
      m_cyc++;
    end
  end

  // expected outputs for this cycle go into the scoreboard
  always @(negedge clk) begin
    if (m_valid) begin
      exp_t e;
      int   slot;
      logic [15:0] d;
      bit   blank;
      slot  = (m_cyc / RD) % 4;
      d     = (m_own == 1) ? data_a : ((m_own == 2) ? data_b : 16'h0);
      blank = rst || m_own == 0 ||
              (blank_lz && slot > 0 && (d >> (4 * slot)) == 16'h0);
      e.cyc = m_cyc;
      e.ga  = (m_own == 1);
      e.gb  = (m_own == 2);
      e.en  = 2'(slot);
      e.ctl = blank ? 4'b1111 : ~(4'b0001 << slot);
      e.din = blank ? 4'h0 : 4'((d >> (4 * slot)) & 16'hF);
      e.fd  = !rst && (m_cyc % FRAME == FRAME - 1);
      sb.push_back(e);
    end
  end

  // monitor: pop expectations and compare to DUT outputs
  always @(negedge clk) begin
    #2;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_chk++;
      if (grant_a !== e.ga || grant_b !== e.gb ||
          ssd_en_ctl !== e.en || ssd_ctl !== e.ctl ||
          ssd_in !== e.din || frame_done !== e.fd) begin
        n_err++;
        $display("FAIL outputs cyc=%0d got ga=%b gb=%b en=%0d ctl=%b in=%h fd=%b exp ga=%b gb=%b en=%0d ctl=%b in=%h fd=%b",
                 e.cyc, grant_a, grant_b, ssd_en_ctl, ssd_ctl, ssd_in,
                 frame_done, e.ga, e.gb, e.en, e.ctl, e.din, e.fd);
      end
      n_chk++;
      if (grant_a === 1'b1 && grant_b === 1'b1) begin
        n_err++;
        $display("FAIL grant_excl cyc=%0d got ga=1 gb=1 exp at most one",
                 e.cyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic to_phase(input int ph);
    int lim = 0;
    while (m_cyc % FRAME != ph && lim < 2 * FRAME) begin
      step(1);
      lim++;
    end
    n_chk++;
    if (m_cyc % FRAME != ph) begin
      n_err++;
      $display("FAIL phase_wait got %0d exp %0d", m_cyc % FRAME, ph);
    end
  endtask

  task automatic wait_own(input int own);
    int lim = 0;
    while (m_own != own && lim < 4 * FRAME) begin
      step(1);
      lim++;
    end
    n_chk++;
    if (m_own != own) begin
      n_err++;
      $display("FAIL owner_wait got %0d exp %0d", m_own, own);
    end
  endtask

  initial begin
    rst      = 1'b1;
    req_a    = 1'b0;
    req_b    = 1'b0;
    blank_lz = 1'b0;
    data_a   = 16'h0;
    data_b   = 16'h0;
    step(2);
    rst = 1'b0;
    step(2 * FRAME);

    // A requests mid-frame with 1234
    to_phase(5);
    data_a = 16'h1234;
    req_a  = 1'b1;
    step(2 * FRAME);

    // both requesting from reset: rotation
    req_b  = 1'b1;
    data_b = 16'hABCD;
    rst    = 1'b1;
    step(1);
    rst = 1'b0;
    step(7 * FRAME);

    // leading-zero blanking
    req_b    = 1'b0;
    blank_lz = 1'b1;
    data_a   = 16'h0050;
    wait_own(1);
    step(FRAME);
    data_a = 16'h0000;
    step(FRAME);
    data_a = 16'h0F00;
    step(FRAME);
    blank_lz = 1'b0;

    // A drops mid-frame, nobody else wants it
    to_phase(6);
    req_a = 1'b0;
    step(2 * FRAME);

    // reset mid-frame while B owns
    req_b  = 1'b1;
    data_b = 16'h9876;
    wait_own(2);
    to_phase(9);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(2 * FRAME);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) req_a = ~req_a;
      if ($urandom_range(0, 15) == 0) req_b = ~req_b;
      if ($urandom_range(0, 63) == 0) blank_lz = ~blank_lz;
      case ($urandom_range(0, 3))
        0: data_a = 16'($urandom);
        1: data_a = 16'($urandom) & 16'h00FF;
        2: data_a = 16'($urandom) & 16'h000F;
        default: data_a = 16'h0000;
      endcase
      data_b = ($urandom_range(0, 1) == 0) ? 16'($urandom)
                                           : 16'($urandom) & 16'h0FF0;
      rst = ($urandom_range(0, 399) == 0);
      step(1);
    end
    rst = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
